// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and default operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADDER_W_DEF = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full-adder cell used by the serial adder datapath.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = SERIAL_ADDER_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(W + 1);

    state_t         state_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           carry_r;
    logic [CW-1:0]  cnt_r;
    logic           s_s;
    logic           c_s;

    full_adder u_full_adder (
        .x (a_r[0]),
        .y (b_r[0]),
        .z (carry_r),
        .s (s_s),
        .c (c_s)
    );

    // FSM, operand shifters, carry and counter; all outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= {W{1'b0}};
            cout    <= 1'b0;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum     <= {s_s, sum[W-1:1]};
                    a_r     <= {1'b0, a_r[W-1:1]};
                    b_r     <= {1'b0, b_r[W-1:1]};
                    carry_r <= c_s;
                    cnt_r   <= cnt_r + CW'(1);
                    // On the MSB cycle carry_r is the carry into bit W-1.
                    if (cnt_r == CW'(W - 1)) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cout    <= c_s;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf     <= carry_r ^ c_s;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, corner sequences and a random sweep.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ovf(input string name, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
        check(name, {63'd0, ovf}, {63'd0, exp});
`endif
    endtask

    // Reference: plain integer arithmetic, signed overflow from the signed range.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        longint u;
        longint sx;
        longint sy;
        longint ss;
        logic   o;
        u  = longint'(x) + longint'(y) + longint'(z);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ss = sx + sy + longint'(z);
        o  = (ss > ((64'sd1 <<< (W - 1)) - 64'sd1)) || (ss < -(64'sd1 <<< (W - 1)));
        return {o, u[W], u[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        a = ia;
        b = ib;
        cin = ic;
        start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 4 * W) begin
            step();
            lat++;
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step();
            if (done === 1'b1) cnt++;
        end
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic ic, input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        launch(ia, ib, ic);
        check({tag, " busy"}, {63'd0, busy}, 64'd1);
        wait_done(lat);
        // done appears W edges after the accepting edge (cycle W+1 counting the accept cycle as 0).
        check({tag, " latency"}, 64'(lat), 64'(W));
        check({tag, " sum"}, 64'(sum), 64'(es));
        check({tag, " cout"}, {63'd0, cout}, {63'd0, ec});
        check_ovf({tag, " ovf"}, eo);
        step();
        check({tag, " done pulse"}, {63'd0, done}, 64'd0);
        check({tag, " sum held"}, 64'(sum), 64'(es));
    endtask

    initial begin
        int lat;
        int lat2;
        int n;
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};
        vecs[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        step();
        step();
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset sum", 64'(sum), 64'd0);
        check("reset cout", {63'd0, cout}, 64'd0);
        check_ovf("reset ovf", 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                      vecs[i].s, vecs[i].c, vecs[i].o);
        end

        // start during RUN with other operands must be ignored
        launch(8'h12, 8'h34, 1'b0);
        step();
        step();
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat);
        check("ignore latency", 64'(lat + 3), 64'(W));
        check("ignore sum", 64'(sum), 64'h46);
        check("ignore cout", {63'd0, cout}, 64'd0);
        count_done(W + 4, n);
        check("ignore no second done", 64'(n), 64'd0);

        // reset mid-RUN aborts
        launch(8'hA5, 8'h0F, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort sum", 64'(sum), 64'd0);
        check("abort cout", {63'd0, cout}, 64'd0);
        rst = 1'b0;
        count_done(W + 4, n);
        check("abort no done", 64'(n), 64'd0);
        run_check("after abort", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);

        // back-to-back: start held high through DONE
        a = 8'h5A;
        b = 8'h3C;
        cin = 1'b0;
        start = 1'b1;
        step();
        a = 8'hC8;
        b = 8'h64;
        cin = 1'b1;
        wait_done(lat);
        check("b2b first latency", 64'(lat), 64'(W));
        check("b2b first sum", 64'(sum), 64'h96);
        check("b2b first cout", {63'd0, cout}, 64'd0);
        step();
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        check("b2b restart busy", {63'd0, busy}, 64'd1);
        check("b2b restart done low", {63'd0, done}, 64'd0);
        wait_done(lat2);
        check("b2b done spacing", 64'(lat2 + 1), 64'(W + 1));
        check("b2b second sum", 64'(sum), 64'h2D);
        check("b2b second cout", {63'd0, cout}, 64'd1);
        check_ovf("b2b second ovf", 1'b0);
        step();

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            m = model(ra, rb, rc);
            run_check($sformatf("rand%0d", i), ra, rb, rc, m[W-1:0], m[W], m[W+1]);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
